// File: rtl/cr_lz77_comp_tile_feeder_pkg.sv
// Shared types and helpers for the LZ77 compare-tile feeder.
// Frame sequencing states, accumulator sizing and byte-valid popcount.
package cr_lz77_comp_feed_pkg;

    localparam int FEED_IN_BYTES = 4;
    // Worst case holds IN_BYTES-1 leftover bytes plus one full incoming beat.
    localparam int ACC_BYTES     = 2*FEED_IN_BYTES-1;

    typedef enum logic [2:0] {IDLE, PREFIX, DATA, FLUSH, DRAIN} feed_state_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += {31'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/cr_lz77_comp_tile_feeder_if.sv
// Upstream, prefix and tile-side signals of the LZ77 tile feeder.
// slave = feeder, master = whatever drives the byte stream and observes the tile controls.
interface cr_lz77_comp_tile_feeder_if #(
    parameter int IN_BYTES   = 4,
    parameter int SHIFT_MULT = 4
);
    localparam int PH_W = (SHIFT_MULT > 1) ? $clog2(SHIFT_MULT) : 1;

    logic                    frame_start;
    logic                    frame_has_pfx;
    logic [IN_BYTES*8-1:0]   pfx_data;
    logic                    pfx_vld;
    logic                    pfx_last;
    logic                    pfx_rdy;
    logic [IN_BYTES*8-1:0]   up_data;
    logic [IN_BYTES-1:0]     up_vld;
    logic                    up_eof;
    logic                    up_rdy;
    logic [IN_BYTES*8-1:0]   lz77_tile_data;
    logic [IN_BYTES-1:0]     lz77_tile_data_vld;
    logic [IN_BYTES*8-1:0]   lz77_tile_prefix_data;
    logic [IN_BYTES-1:0]     lz77_tile_prefix_data_vld;
    logic                    input_en;
    logic                    shift_en;
    logic                    prefix_en;
    logic                    me_tile_enable;
    logic [PH_W-1:0]         shift_start_phase;
    logic                    cl_ti_clr_valid;
    logic                    frame_done;
    logic                    err_start_busy;

    modport master (
        output frame_start, frame_has_pfx, pfx_data, pfx_vld, pfx_last, up_data, up_vld, up_eof,
        input  pfx_rdy, up_rdy, lz77_tile_data, lz77_tile_data_vld, lz77_tile_prefix_data,
               lz77_tile_prefix_data_vld, input_en, shift_en, prefix_en, me_tile_enable,
               shift_start_phase, cl_ti_clr_valid, frame_done, err_start_busy
    );

    modport slave (
        input  frame_start, frame_has_pfx, pfx_data, pfx_vld, pfx_last, up_data, up_vld, up_eof,
        output pfx_rdy, up_rdy, lz77_tile_data, lz77_tile_data_vld, lz77_tile_prefix_data,
               lz77_tile_prefix_data_vld, input_en, shift_en, prefix_en, me_tile_enable,
               shift_start_phase, cl_ti_clr_valid, frame_done, err_start_busy
    );

endinterface

// File: rtl/cr_lz77_comp_byte_packer.sv
// Byte accumulator: appends ragged beats behind the held bytes and drops the emitted word.
// Bytes at or above acc_cnt are always zero, so a partial word needs no extra masking.
module cr_lz77_comp_byte_packer
    import cr_lz77_comp_feed_pkg::*;
#(
    parameter int IN_BYTES = FEED_IN_BYTES,
    parameter int ACC_B    = ACC_BYTES,
    parameter int CNT_W    = $clog2(ACC_B+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accept,
    input  logic [IN_BYTES*8-1:0] in_data,
    input  logic [CNT_W-1:0]      in_cnt,
    input  logic                  emit_full,
    input  logic                  emit_part,
    output logic [CNT_W-1:0]      acc_cnt,
    output logic [CNT_W-1:0]      acc_cnt_nxt,
    output logic [IN_BYTES*8-1:0] word
);
    localparam int ACC_W = ACC_B*8;

    logic [ACC_W-1:0]      acc_data;
    logic [ACC_W-1:0]      acc_data_nxt;
    logic [ACC_W-1:0]      shifted;
    logic [ACC_W-1:0]      incoming;
    logic [IN_BYTES*8-1:0] in_masked;
    logic [CNT_W-1:0]      n_emit;
    logic [CNT_W-1:0]      base;

    always_comb begin
        n_emit = '0;
        if (emit_full)      n_emit = CNT_W'(IN_BYTES);
        else if (emit_part) n_emit = acc_cnt;
        base = acc_cnt - n_emit;

        in_masked = '0;
        for (int i = 0; i < IN_BYTES; i++)
            if (CNT_W'(i) < in_cnt) in_masked[i*8 +: 8] = in_data[i*8 +: 8];

        shifted  = acc_data >> {n_emit, 3'b000};
        incoming = '0;
        if (accept) incoming = ACC_W'(in_masked) << {base, 3'b000};
        acc_data_nxt = shifted | incoming;
        acc_cnt_nxt  = base + (accept ? in_cnt : '0);
    end

    assign word = acc_data[IN_BYTES*8-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data <= '0;
            acc_cnt  <= '0;
        end else begin
            acc_data <= acc_data_nxt;
            acc_cnt  <= acc_cnt_nxt;
        end
    end

endmodule

// File: rtl/cr_lz77_comp_tile_feeder.sv
// LZ77 tile feeder: frame FSM, emit gap / phase / drain counters and registered tile controls.
// Every output is a flop so the first tile sees clean strobes.
module cr_lz77_comp_tile_feeder
    import cr_lz77_comp_feed_pkg::*;
#(
    parameter int IN_BYTES     = FEED_IN_BYTES,
    parameter int SHIFT_MULT   = 4,
    parameter int MIN_GAP      = 1,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    cr_lz77_comp_tile_feeder_if.slave  bus
);
    localparam int ACC_B = 2*IN_BYTES-1;
    localparam int CNT_W = $clog2(ACC_B+1);
    localparam int PH_W  = (SHIFT_MULT > 1) ? $clog2(SHIFT_MULT) : 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int DR_W  = $clog2(DRAIN_CYCLES+1);

    feed_state_e           state, state_d;
    logic [GAP_W-1:0]      gap_cnt;
    logic [PH_W-1:0]       phase;
    logic [DR_W-1:0]       drain_cnt;
    logic                  up_acc, pfx_acc, emit_ok, emit_full, emit_part;
    logic [CNT_W-1:0]      acc_cnt, acc_cnt_nxt, in_cnt;
    logic [IN_BYTES*8-1:0] word;
    logic [IN_BYTES-1:0]   part_mask;

    cr_lz77_comp_byte_packer #(
        .IN_BYTES (IN_BYTES),
        .ACC_B    (ACC_B),
        .CNT_W    (CNT_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .accept      (up_acc),
        .in_data     (bus.up_data),
        .in_cnt      (in_cnt),
        .emit_full   (emit_full),
        .emit_part   (emit_part),
        .acc_cnt     (acc_cnt),
        .acc_cnt_nxt (acc_cnt_nxt),
        .word        (word)
    );

    always_comb begin
        up_acc    = bus.up_rdy & ((|bus.up_vld) | bus.up_eof);
        pfx_acc   = bus.pfx_vld & bus.pfx_rdy;
        in_cnt    = CNT_W'(popcount(32'(bus.up_vld)));
        emit_ok   = ((state == DATA) || (state == FLUSH)) && (gap_cnt == '0);
        emit_full = emit_ok && (acc_cnt >= CNT_W'(IN_BYTES));
        // Short words only go out once the frame has ended; in DATA they wait for more bytes.
        emit_part = emit_ok && (state == FLUSH) && (acc_cnt != '0) && (acc_cnt < CNT_W'(IN_BYTES));
        part_mask = IN_BYTES'((1 << acc_cnt) - 1);

        state_d = state;
        case (state)
            IDLE:    if (bus.frame_start) state_d = bus.frame_has_pfx ? PREFIX : DATA;
            PREFIX:  if (pfx_acc && bus.pfx_last) state_d = DATA;
            DATA:    if (up_acc && bus.up_eof) state_d = FLUSH;
            FLUSH:   if (acc_cnt_nxt == '0) state_d = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                         <= IDLE;
            gap_cnt                       <= '0;
            phase                         <= '0;
            drain_cnt                     <= '0;
            bus.pfx_rdy                   <= 1'b0;
            bus.up_rdy                    <= 1'b0;
            bus.lz77_tile_data            <= '0;
            bus.lz77_tile_data_vld        <= '0;
            bus.lz77_tile_prefix_data     <= '0;
            bus.lz77_tile_prefix_data_vld <= '0;
            bus.input_en                  <= 1'b0;
            bus.shift_en                  <= 1'b0;
            bus.prefix_en                 <= 1'b0;
            bus.me_tile_enable            <= 1'b0;
            bus.shift_start_phase         <= '0;
            bus.cl_ti_clr_valid           <= 1'b0;
            bus.frame_done                <= 1'b0;
            bus.err_start_busy            <= 1'b0;
        end else begin
            state <= state_d;

            if (emit_full || emit_part)  gap_cnt <= GAP_W'(MIN_GAP-1);
            else if (gap_cnt != '0)      gap_cnt <= gap_cnt - 1'b1;

            if (state == IDLE && bus.frame_start) phase <= '0;
            else if (emit_full || emit_part)
                phase <= (phase == PH_W'(SHIFT_MULT-1)) ? '0 : phase + 1'b1;

            // Drain window starts on the cycle the last word is handed to the tile.
            if (state != DRAIN && state_d == DRAIN) drain_cnt <= DR_W'(DRAIN_CYCLES-1);
            else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;

            bus.input_en <= emit_full | emit_part;
            bus.shift_en <= emit_full;
            if (emit_full || emit_part) begin
                bus.lz77_tile_data     <= word;
                bus.lz77_tile_data_vld <= emit_full ? '1 : part_mask;
                bus.shift_start_phase  <= phase;
            end else begin
                bus.lz77_tile_data_vld <= '0;
            end

            bus.prefix_en                 <= pfx_acc;
            bus.lz77_tile_prefix_data_vld <= pfx_acc ? '1 : '0;
            if (pfx_acc) bus.lz77_tile_prefix_data <= bus.pfx_data;

            bus.me_tile_enable  <= (state_d != IDLE);
            bus.pfx_rdy         <= (state_d == PREFIX);
            bus.up_rdy          <= (state_d == DATA) && (acc_cnt_nxt <= CNT_W'(IN_BYTES-1));
            bus.cl_ti_clr_valid <= (state == DRAIN) && (drain_cnt == '0);
            bus.frame_done      <= (state == DRAIN) && (drain_cnt == '0);
            bus.err_start_busy  <= bus.frame_start && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_cr_lz77_comp_tile_feeder.sv
// Directed bench for cr_lz77_comp_tile_feeder: table of frames plus hand-written corner sequences.
// A second instance with MIN_GAP=4 covers emit spacing and upstream backpressure.
module tb_cr_lz77_comp_tile_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cr_lz77_comp_tile_feeder_if #(.IN_BYTES(4), .SHIFT_MULT(4)) b0 ();
    cr_lz77_comp_tile_feeder_if #(.IN_BYTES(4), .SHIFT_MULT(4)) b1 ();

    cr_lz77_comp_tile_feeder #(.IN_BYTES(4), .SHIFT_MULT(4), .MIN_GAP(1), .DRAIN_CYCLES(8))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    cr_lz77_comp_tile_feeder #(.IN_BYTES(4), .SHIFT_MULT(4), .MIN_GAP(4), .DRAIN_CYCLES(8))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  v;
        logic        s;
        logic [1:0]  p;
    } word_t;

    typedef struct {
        int               nb;
        logic [2:0][3:0]  bv;
        logic [2:0][31:0] bd;
        int               nw;
        logic [2:0][31:0] wd;
        logic [2:0][3:0]  wv;
        logic [2:0]       ws;
        logic [2:0][1:0]  wp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          clr_cyc = 0;
    int          clr_cnt = 0;
    int          last_ie = 0;
    word_t       wq[$];
    logic [35:0] pq[$];
    int          q1[$];
    vec_t        vt[4];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (b0.input_en === 1'b1) begin
            wq.push_back({b0.lz77_tile_data, b0.lz77_tile_data_vld, b0.shift_en, b0.shift_start_phase});
            last_ie = cyc;
        end
        if (b0.prefix_en === 1'b1)
            pq.push_back({b0.lz77_tile_prefix_data, b0.lz77_tile_prefix_data_vld});
        if (b0.cl_ti_clr_valid === 1'b1) begin
            clr_cyc = cyc;
            clr_cnt = clr_cnt + 1;
        end
        if (b1.input_en === 1'b1) q1.push_back(cyc);
    end

    always @(posedge clk)
        assert ((b0.up_vld & (b0.up_vld + 4'd1)) == 4'd0 && (b1.up_vld & (b1.up_vld + 4'd1)) == 4'd0)
        else $error("illegal non-contiguous up_vld");

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] outs0();
        return 128'({b0.pfx_rdy, b0.up_rdy, b0.lz77_tile_data, b0.lz77_tile_data_vld,
                     b0.lz77_tile_prefix_data, b0.lz77_tile_prefix_data_vld, b0.input_en,
                     b0.shift_en, b0.prefix_en, b0.me_tile_enable, b0.shift_start_phase,
                     b0.cl_ti_clr_valid, b0.frame_done, b0.err_start_busy});
    endfunction

    task automatic start_frame(input logic has_pfx);
        b0.frame_start = 1'b1;
        b0.frame_has_pfx = has_pfx;
        @(posedge clk); #1;
        b0.frame_start = 1'b0;
        b0.frame_has_pfx = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] v, input logic [31:0] d, input logic e);
        int n;
        n = 0;
        b0.up_vld = v; b0.up_data = d; b0.up_eof = e;
        @(negedge clk);
        while (b0.up_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (b0.up_rdy !== 1'b1) chk("up_rdy_wait", b0.up_rdy, 1);
        @(posedge clk); #1;
        b0.up_vld = '0; b0.up_eof = 1'b0;
    endtask

    task automatic send_pfx(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        b0.pfx_data = d; b0.pfx_vld = 1'b1; b0.pfx_last = last;
        @(negedge clk);
        while (b0.pfx_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (b0.pfx_rdy !== 1'b1) chk("pfx_rdy_wait", b0.pfx_rdy, 1);
        @(posedge clk); #1;
        b0.pfx_vld = 1'b0; b0.pfx_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (b0.frame_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("frame_done", b0.frame_done, 1);
        chk("clr_with_done", b0.cl_ti_clr_valid, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, waits;
        b0.frame_start = 0; b0.frame_has_pfx = 0; b0.pfx_data = '0; b0.pfx_vld = 0;
        b0.pfx_last = 0; b0.up_data = '0; b0.up_vld = '0; b0.up_eof = 0;
        b1.frame_start = 0; b1.frame_has_pfx = 0; b1.pfx_data = '0; b1.pfx_vld = 0;
        b1.pfx_last = 0; b1.up_data = '0; b1.up_vld = '0; b1.up_eof = 0;

        vt[0] = '{3, {4'h3, 4'h7, 4'h7}, {32'hEEEE8877, 32'hAA665544, 32'hAA332211},
                  2, {32'h0, 32'h88776655, 32'h44332211}, {4'h0, 4'hf, 4'hf}, 3'b011, {2'd0, 2'd1, 2'd0}};
        vt[1] = '{2, {4'h0, 4'h1, 4'hf}, {32'h0, 32'hFFFFFF5A, 32'hDDCCBBAA},
                  2, {32'h0, 32'h0000005A, 32'hDDCCBBAA}, {4'h0, 4'h1, 4'hf}, 3'b001, {2'd0, 2'd0, 2'd0}};
        vt[2] = '{3, {4'h3, 4'hf, 4'hf}, {32'hFFFF0A09, 32'h08070605, 32'h04030201},
                  3, {32'h00000A09, 32'h08070605, 32'h04030201}, {4'h3, 4'hf, 4'hf}, 3'b011, {2'd0, 2'd1, 2'd0}};
        vt[3] = '{3, {4'hf, 4'h1, 4'h3}, {32'h77665544, 32'hCCCCCC33, 32'hCCCC2211},
                  2, {32'h0, 32'h00776655, 32'h44332211}, {4'h0, 4'h7, 4'hf}, 3'b001, {2'd0, 2'd0, 2'd0}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", outs0(), 0);
        @(posedge clk); #1;

        // Reset in the middle of a frame with three bytes held.
        start_frame(1'b0);
        send_beat(4'h7, 32'h00332211, 1'b0);
        chk("pre_rst_me", b0.me_tile_enable, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midframe_rst_outputs", outs0(), 0);
        n = clr_cnt;
        repeat (15) @(negedge clk);
        chk("midframe_rst_no_clr", clr_cnt, n);
        chk("midframe_rst_no_word", wq.size(), 0);
        chk("midframe_rst_idle", b0.me_tile_enable, 0);
        @(posedge clk); #1;

        // Prefix phase with three words, then a single data word.
        start_frame(1'b1);
        chk("pfx_rdy_in_prefix", b0.pfx_rdy, 1);
        send_pfx(32'hA0A1A2A3, 1'b0);
        send_pfx(32'hB0B1B2B3, 1'b0);
        send_pfx(32'hC0C1C2C3, 1'b1);
        @(negedge clk);
        chk("up_rdy_after_pfx", b0.up_rdy, 1);
        chk("pfx_rdy_after_last", b0.pfx_rdy, 0);
        @(posedge clk); #1;
        send_beat(4'hf, 32'h12345678, 1'b1);
        wait_done();
        chk("pfx_count", pq.size(), 3);
        if (pq.size() == 3) begin
            chk("pfx_word0", pq[0], {32'hA0A1A2A3, 4'hf});
            chk("pfx_word1", pq[1], {32'hB0B1B2B3, 4'hf});
            chk("pfx_word2", pq[2], {32'hC0C1C2C3, 4'hf});
        end
        chk("pfx_frame_words", wq.size(), 1);
        if (wq.size() == 1) chk("pfx_frame_word", wq[0], {32'h12345678, 4'hf, 1'b1, 2'd0});

        for (int i = 0; i < 4; i++) begin
            wq.delete();
            start_frame(1'b0);
            for (int j = 0; j < vt[i].nb; j++)
                send_beat(vt[i].bv[j], vt[i].bd[j], j == vt[i].nb - 1);
            wait_done();
            chk($sformatf("vec%0d_nwords", i), wq.size(), vt[i].nw);
            for (int k = 0; k < vt[i].nw && k < wq.size(); k++) begin
                chk($sformatf("vec%0d_w%0d_data", i, k), wq[k].d, vt[i].wd[k]);
                chk($sformatf("vec%0d_w%0d_vld", i, k), wq[k].v, vt[i].wv[k]);
                chk($sformatf("vec%0d_w%0d_shift", i, k), wq[k].s, vt[i].ws[k]);
                if (vt[i].ws[k]) chk($sformatf("vec%0d_w%0d_phase", i, k), wq[k].p, vt[i].wp[k]);
            end
            chk($sformatf("vec%0d_clr_delay", i), clr_cyc - last_ie, 8);
        end

        // frame_start while draining is refused and flagged for one cycle.
        wq.delete();
        start_frame(1'b0);
        send_beat(4'hf, 32'h0BADF00D, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        b0.frame_start = 1'b1;
        @(posedge clk); #1;
        b0.frame_start = 1'b0;
        @(negedge clk);
        chk("err_start_busy_pulse", b0.err_start_busy, 1);
        @(negedge clk);
        chk("err_start_busy_clear", b0.err_start_busy, 0);
        wait_done();
        chk("busy_frame_words", wq.size(), 1);
        chk("busy_frame_clr_delay", clr_cyc - last_ie, 8);
        @(negedge clk);
        chk("busy_start_ignored", {b0.me_tile_enable, b0.up_rdy}, 2'b00);
        @(posedge clk); #1;

        // Frame consisting of a single eof-only beat.
        wq.delete();
        n = clr_cnt;
        start_frame(1'b0);
        send_beat(4'h0, 32'h0, 1'b1);
        wait_done();
        chk("eof_only_no_word", wq.size(), 0);
        chk("eof_only_clr", clr_cnt - n, 1);

        // MIN_GAP=4 instance: twelve bytes offered back-to-back.
        waits = 0;
        b1.frame_start = 1'b1;
        @(posedge clk); #1;
        b1.frame_start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            b1.up_vld = 4'hf;
            b1.up_data = 32'h11111111 * (j + 1);
            b1.up_eof = (j == 2);
            n = 0;
            @(negedge clk);
            while (b1.up_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            waits += n;
            @(posedge clk); #1;
            b1.up_vld = '0; b1.up_eof = 1'b0;
        end
        n = 0;
        while (b1.frame_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("gap_frame_done", b1.frame_done, 1);
        @(posedge clk); #1;
        chk("gap_word_count", q1.size(), 3);
        if (q1.size() == 3) begin
            chk("gap_spacing_01", q1[1] - q1[0], 4);
            chk("gap_spacing_12", q1[2] - q1[1], 4);
        end
        chk("gap_backpressure", waits > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
